// File: rtl/vga_pkg.sv
// Shared VGA timing types and the default 800x600@60 (40 MHz pixel clock) timing set.
package vga_pkg;

  localparam int unsigned DEF_CNT_W   = 11;
  localparam int unsigned DEF_FRAME_W = 16;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
    logic      h_pol;
    logic      v_pol;
  } vga_timing_t;

  localparam vga_timing_t DEF_TIMING = '{
    h:     '{16'd800, 16'd40, 16'd128, 16'd88},
    v:     '{16'd600, 16'd1,  16'd4,   16'd23},
    h_pol: 1'b1,
    v_pol: 1'b1
  };

endpackage

// File: rtl/vga_if.sv
// Timing bundle at the head of the draw pipeline; `out` is the timing source, `in` the consumer.
interface vga_if #(
  parameter int unsigned CNT_W   = vga_pkg::DEF_CNT_W,
  parameter int unsigned FRAME_W = vga_pkg::DEF_FRAME_W
);
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk,
                      line_start, frame_start, frame_cnt);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk,
                      line_start, frame_start, frame_cnt);
endinterface

// File: rtl/vga_wrap_cnt.sv
// Wrapping up-counter with clear priority; exposes its next value so decode logic can
// be registered in lock-step with the count.
module vga_wrap_cnt #(
  parameter int unsigned W   = 11,
  parameter int unsigned MAX = 1055
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_nxt_c,
  output logic         wrap_c
);

  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_c = en && (cnt_q == W'(MAX));
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap_c ? '0 : cnt_q + W'(1);
    end
  end

  assign cnt_nxt_c = cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync/blank decode and line/frame markers,
// all registered and decoded from the next count so nothing skews against hcount/vcount.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned H_ACTIVE = 32'(DEF_TIMING.h.active),
  parameter int unsigned H_FP     = 32'(DEF_TIMING.h.fp),
  parameter int unsigned H_SYNC   = 32'(DEF_TIMING.h.sync),
  parameter int unsigned H_BP     = 32'(DEF_TIMING.h.bp),
  parameter int unsigned V_ACTIVE = 32'(DEF_TIMING.v.active),
  parameter int unsigned V_FP     = 32'(DEF_TIMING.v.fp),
  parameter int unsigned V_SYNC   = 32'(DEF_TIMING.v.sync),
  parameter int unsigned V_BP     = 32'(DEF_TIMING.v.bp),
  parameter int unsigned H_POL    = 32'(DEF_TIMING.h_pol),
  parameter int unsigned V_POL    = 32'(DEF_TIMING.v_pol),
  parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_clr,
  vga_if.out   vga
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam logic        H_LVL      = 1'(H_POL);
  localparam logic        V_LVL      = 1'(V_POL);

  if (CNT_W == 0 || CNT_W > 32 || FRAME_W == 0 || H_ACTIVE == 0 || H_SYNC == 0 ||
      V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_width
    $error("vga_timing_gen: width parameter out of range");
  end
  if (64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  logic [CNT_W-1:0]   h_cnt, v_cnt, h_nxt_c, v_nxt_c;
  logic               h_wrap_c, v_wrap_c;
  logic               hsync_d, hsync_q, vsync_d, vsync_q;
  logic               hblnk_d, hblnk_q, vblnk_d, vblnk_q;
  logic               line_start_d, line_start_q, frame_start_d, frame_start_q;
  logic [FRAME_W-1:0] frame_cnt_d, frame_cnt_q;

  vga_wrap_cnt #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_en),
    .clr       (sync_clr),
    .cnt_q     (h_cnt),
    .cnt_nxt_c (h_nxt_c),
    .wrap_c    (h_wrap_c)
  );

  vga_wrap_cnt #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_en & h_wrap_c),
    .clr       (sync_clr),
    .cnt_q     (v_cnt),
    .cnt_nxt_c (v_nxt_c),
    .wrap_c    (v_wrap_c)
  );

  // Compare in 32 bits so a sync end equal to 2**CNT_W cannot truncate to zero.
  always_comb begin
    hblnk_d       = 32'(h_nxt_c) >= H_ACTIVE;
    vblnk_d       = 32'(v_nxt_c) >= V_ACTIVE;
    hsync_d       = ~H_LVL;
    vsync_d       = ~V_LVL;
    line_start_d  = sync_clr | h_wrap_c;
    frame_start_d = sync_clr | (h_wrap_c & v_wrap_c);
    frame_cnt_d   = frame_cnt_q;
    if (32'(h_nxt_c) >= H_SYNC_BEG && 32'(h_nxt_c) < H_SYNC_END) hsync_d = H_LVL;
    if (32'(v_nxt_c) >= V_SYNC_BEG && 32'(v_nxt_c) < V_SYNC_END) vsync_d = V_LVL;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~H_LVL;
      vsync_q       <= ~V_LVL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga.hcount      = h_cnt;
  assign vga.vcount      = v_cnt;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.hblnk       = hblnk_q;
  assign vga.vblnk       = vblnk_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule
